dmem_access_ctrl: RTL and testbench
===================================

// Module: dmem_access_ctrl
// PURPOSE
// Sequences all accesses to the single-port synchronous data memory.
// Arbitrates between the core MEM stage (loads/stores, RV32 funct3 encoded) and the program loader (word writes only).
// Handles byte/halfword extraction with sign/zero extension and sub-word stores via read-modify-write.
// Reports misaligned or illegal accesses without touching memory.
// PARAMETERS
// ADDR_W      5  word-index width of data memory (2**ADDR_W words, 32 by default)
// STARVE_MAX  4  consecutive core grants tolerated while loader waits before loader is forced
// PORTS
// clk        in   1       clock, rising edge
// n_rst      in   1       async active-low reset
// c_req      in   1       core request valid; held until c_ready
// c_ready    out  1       core request accepted this cycle (comb, IDLE only)
// c_we       in   1       1=store, 0=load
// c_funct3   in   3       000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 (stores)
// c_addr     in   32      byte address
// c_wdata    in   32      store data, low bytes used for SB/SH
// c_rvalid   out  1       registered 1-cycle completion pulse (loads and stores)
// c_rdata    out  32      load result, extended; 0 for stores and errors
// c_err      out  1       with c_rvalid: misaligned or illegal funct3
// l_req      in   1       loader write request; held until l_ready
// l_ready    out  1       loader request accepted this cycle (comb)
// l_addr     in   32      byte address, word aligned (addr[1:0] ignored)
// l_wdata    in   32      write word
// mem_en     out  1       memory enable
// mem_we     out  1       memory write enable
// mem_addr   out  ADDR_W  word index = addr[ADDR_W+1:2]; upper address bits ignored
// mem_wdata  out  32      write word
// mem_rdata  in   32      read data, valid the cycle after mem_en & !mem_we
// BEHAVIOUR
// - Reset: state IDLE, starve count 0, all outputs 0. Reset mid-op aborts and drops the op: no write, no c_rvalid after release.
// - Request fields latched at accept; requester may change them the cycle after.
// - FSM states: IDLE, WR, RD, WAIT, MRG, ERR. mem_* decoded from state and latched regs.
// - IDLE arbitration: core wins, unless l_req && starve==STARVE_MAX, then loader wins.
//   - starve increments on each core grant while l_req is high; it clears on a loader grant.
// - Core accept, illegal or misaligned -> ERR, no memory access.
//   - Misaligned: H with addr[0]; W with addr[1:0]!=0. Illegal: funct3 011/110/111, or BU/HU with c_we.
// - Loader accept, or core SW -> WR (mem_en=mem_we=1) -> IDLE.
// - Core load -> RD (mem_en=1) -> WAIT: extract the lane per addr[1:0] and extend -> IDLE.
// - Core SB/SH -> RD -> WAIT: capture mem_rdata and merge the new bytes -> MRG (write merged word) -> IDLE.
// - Latency from accept cycle T:
//   - c_rvalid at T+1 for ERR, T+2 for SW, T+3 for loads, T+4 for SB/SH.
//   - Loader write reaches memory at T+1; loader gets no response.
// - A new accept is allowed in the cycle c_rvalid is high (back-to-back).
// - Ordering is grant order; a load after a store to the same word returns the new data.
// STRUCTURE
// - dmem_pkg: state enum; funct3 constants (F3_B/H/W/BU/HU).
// - Sub-module dmem_lane_align (comb): extract+extend for loads, byte-merge for sub-word stores.
// TESTING
// - Core SW 0xDEADBEEF @0x8, then LW @0x8 -> mem write at T+1; c_rdata=0xDEADBEEF, c_err=0 at T+3.
// - Word 0x8 holds 0x11223344; SB 0xAA @0x9 -> memory 0x1122AA44. LB @0x9 -> 0xFFFFFFAA; LBU @0x9 -> 0x000000AA.
// - LH @0x3 and SW @0x6 -> c_rvalid at T+1 with c_err=1, c_rdata=0; mem_en never asserted.
// - c_req and l_req held high continuously -> l_ready after 4 core grants (STARVE_MAX=4); pattern repeats.
// - n_rst low in MRG state of an SB -> no mem_we; after release all outputs 0, state IDLE, memory word unchanged.
// - Loader writes 0x12345678 @0x7C, then core LW @0x7C -> 0x12345678; address 0x87C aliases to word 31.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and funct3 decode helpers for the data-memory access controller.
package dmem_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StRd,
    StWait,
    StMrg,
    StErr
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // True when the access must be rejected: misaligned, unknown funct3, or unsigned store.
  function automatic logic access_bad(input logic [2:0] funct3, input logic we,
                                      input logic [1:0] off);
    logic bad;
    case (funct3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = off[0];
      F3_W:    bad = |off;
      F3_BU:   bad = we;
      F3_HU:   bad = we | off[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte/halfword lane handling: load extraction with extension, and sub-word store merge.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{off, 3'b000} +: 8];
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'h0, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'h0, half_sel};
      default: load_data = rdata;
    endcase
  end

  always_comb begin
    merged = rdata;
    if (funct3 == F3_H) begin
      merged[{off[1], 4'b0000} +: 16] = wdata[15:0];
    end else begin
      merged[{off, 3'b000} +: 8] = wdata[7:0];
    end
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Sequences core and loader accesses onto a single-port synchronous data memory,
// with starvation-bounded arbitration and read-modify-write for sub-word stores.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              c_req,
  output logic              c_ready,
  input  logic              c_we,
  input  logic [2:0]        c_funct3,
  input  logic [31:0]       c_addr,
  input  logic [31:0]       c_wdata,
  output logic              c_rvalid,
  output logic [31:0]       c_rdata,
  output logic              c_err,
  input  logic              l_req,
  output logic              l_ready,
  input  logic [31:0]       l_addr,
  input  logic [31:0]       l_wdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);

  state_e              state_q, state_d;
  logic [StarveW-1:0]  starve_q, starve_d;
  logic [ADDR_W+1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [2:0]          funct3_q, funct3_d;
  logic                store_q, store_d;
  logic                core_q, core_d;
  logic                rvalid_q, rvalid_d;
  logic                err_q, err_d;
  logic [31:0]         rdata_q, rdata_d;

  logic                l_grant, c_grant, c_bad;
  logic [31:0]         load_data, merged;

  dmem_lane_align u_lane_align (
    .funct3    (funct3_q),
    .off       (addr_q[1:0]),
    .rdata     (mem_rdata),
    .wdata     (wdata_q),
    .load_data (load_data),
    .merged    (merged)
  );

  always_comb begin
    l_grant = (state_q == StIdle) && l_req &&
              (!c_req || (starve_q == StarveW'(STARVE_MAX)));
    c_grant = (state_q == StIdle) && c_req && !l_grant;
    c_bad   = access_bad(c_funct3, c_we, c_addr[1:0]);
  end

  assign c_ready  = c_grant;
  assign l_ready  = l_grant;
  assign c_rvalid = rvalid_q;
  assign c_rdata  = rdata_q;
  assign c_err    = err_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (l_grant) begin
          state_d = StWr;
        end else if (c_grant) begin
          if (c_bad)                           state_d = StErr;
          else if (c_we && c_funct3 == F3_W)   state_d = StWr;
          else                                 state_d = StRd;
        end
      end
      StRd:               state_d = StWait;
      StWait:             state_d = store_q ? StMrg : StIdle;
      StWr, StMrg, StErr: state_d = StIdle;
      default:            state_d = StIdle;
    endcase
  end

  // Request capture at accept; the WAIT cycle overwrites wdata with the merged word.
  always_comb begin
    starve_d = starve_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    store_d  = store_q;
    core_d   = core_q;
    if (l_grant) begin
      starve_d = '0;
      addr_d   = l_addr[ADDR_W+1:0];
      wdata_d  = l_wdata;
      funct3_d = F3_W;
      store_d  = 1'b1;
      core_d   = 1'b0;
    end else if (c_grant) begin
      if (l_req) starve_d = starve_q + 1'b1;
      addr_d   = c_addr[ADDR_W+1:0];
      wdata_d  = c_wdata;
      funct3_d = c_funct3;
      store_d  = c_we;
      core_d   = 1'b1;
    end
    if (state_q == StWait && store_q) wdata_d = merged;
  end

  always_comb begin
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    rdata_d  = '0;
    unique case (state_q)
      StIdle: begin
        if (c_grant && c_bad) begin
          rvalid_d = 1'b1;
          err_d    = 1'b1;
        end
      end
      StWr:   rvalid_d = core_q;
      StWait: begin
        if (!store_q) begin
          rvalid_d = 1'b1;
          rdata_d  = load_data;
        end
      end
      StMrg:  rvalid_d = 1'b1;
      default: ;
    endcase
    mem_en    = state_q inside {StWr, StRd, StMrg};
    mem_we    = state_q inside {StWr, StMrg};
    mem_addr  = mem_en ? addr_q[ADDR_W+1:2] : '0;
    mem_wdata = mem_we ? wdata_q : '0;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      starve_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      store_q  <= 1'b0;
      core_q   <= 1'b0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      starve_q <= starve_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      store_q  <= store_d;
      core_q   <= core_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl with a behavioural synchronous memory.
module tb_dmem_access_ctrl;
  import dmem_pkg::*;

  localparam int unsigned ADDR_W     = 5;
  localparam int unsigned STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              n_rst = 1'b0;
  logic              c_req = 1'b0, c_we = 1'b0;
  logic [2:0]        c_funct3 = '0;
  logic [31:0]       c_addr = '0, c_wdata = '0;
  logic              c_ready, c_rvalid, c_err;
  logic [31:0]       c_rdata;
  logic              l_req = 1'b0;
  logic              l_ready;
  logic [31:0]       l_addr = '0, l_wdata = '0;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata = '0;
  logic [31:0]       mem [32] = '{default: '0};

  dmem_access_ctrl #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .c_req     (c_req),
    .c_ready   (c_ready),
    .c_we      (c_we),
    .c_funct3  (c_funct3),
    .c_addr    (c_addr),
    .c_wdata   (c_wdata),
    .c_rvalid  (c_rvalid),
    .c_rdata   (c_rdata),
    .c_err     (c_err),
    .l_req     (l_req),
    .l_ready   (l_ready),
    .l_addr    (l_addr),
    .l_wdata   (l_wdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int unsigned lat;
    int unsigned acc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;
  int unsigned mem_en_cnt = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every completion pulse pops the oldest expectation.
  always @(negedge clk) begin
    if (mem_en) mem_en_cnt++;
    if (n_rst && c_rvalid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rvalid: got rdata 0x%08h err %0b, expected no response",
                 c_rdata, c_err);
      end else begin
        mon_e = exp_q.pop_front();
        chk({mon_e.name, "_rdata"}, c_rdata, mon_e.rdata);
        chk({mon_e.name, "_err"}, 32'(c_err), 32'(mon_e.err));
        chk({mon_e.name, "_lat"}, cyc - mon_e.acc, mon_e.lat);
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the request.
  task automatic core_op(input string name, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input int unsigned lat);
    int   n = 0;
    exp_t e;
    c_req = 1'b1; c_we = we; c_funct3 = f3; c_addr = addr; c_wdata = wdata;
    @(negedge clk);
    while (!c_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_accept"}, 32'(c_ready), 32'h1);
    if (c_ready) begin
      e.name = name; e.rdata = exp_rdata; e.err = exp_err; e.lat = lat; e.acc = cyc;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    c_req = 1'b0; c_we = ~we; c_funct3 = 3'b111; c_addr = 32'hFFFF_FFFF; c_wdata = 32'h5A5A_5A5A;
  endtask

  task automatic l_op(input string name, input logic [31:0] addr, input logic [31:0] data);
    int n = 0;
    l_req = 1'b1; l_addr = addr; l_wdata = data;
    @(negedge clk);
    while (!l_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_accept"}, 32'(l_ready), 32'h1);
    @(posedge clk); #1;
    l_req = 1'b0; l_addr = 32'hFFFF_FFFF; l_wdata = 32'h0;
  endtask

  // Checks the write strobe in the cycle right after an accept.
  task automatic chk_wr(input string name, input logic [ADDR_W-1:0] idx,
                        input logic [31:0] data);
    @(negedge clk);
    chk({name, "_en_we"}, {30'b0, mem_en, mem_we}, 32'h3);
    chk({name, "_addr"}, 32'(mem_addr), 32'(idx));
    chk({name, "_wdata"}, mem_wdata, data);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'h0);
    @(posedge clk); #1;
  endtask

  task automatic chk_idle_outputs(input string name);
    chk({name, "_ctrl"}, {26'b0, c_ready, l_ready, c_rvalid, c_err, mem_en, mem_we}, 32'h0);
    chk({name, "_rdata"}, c_rdata, 32'h0);
    chk({name, "_maddr"}, 32'(mem_addr), 32'h0);
    chk({name, "_mwdata"}, mem_wdata, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned cnt0;
    int          grants;
    int          n;
    logic [9:0]  seq;
    exp_t        e;

    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    n_rst = 1'b1;
    @(posedge clk); #1;

    // Word store then load, back to back.
    core_op("sw_8", 1'b1, F3_W, 32'h8, 32'hDEAD_BEEF, 32'h0, 1'b0, 2);
    chk_wr("sw_8_mem", 5'd2, 32'hDEAD_BEEF);
    core_op("lw_8", 1'b0, F3_W, 32'h8, 32'h0, 32'hDEAD_BEEF, 1'b0, 3);
    drain();

    // Sub-word stores and extending loads.
    core_op("sw_8b", 1'b1, F3_W, 32'h8, 32'h1122_3344, 32'h0, 1'b0, 2);
    core_op("sb_9", 1'b1, F3_B, 32'h9, 32'hFFFF_FFAA, 32'h0, 1'b0, 4);
    drain();
    chk("sb_9_word", mem[2], 32'h1122_AA44);
    core_op("lb_9", 1'b0, F3_B, 32'h9, 32'h0, 32'hFFFF_FFAA, 1'b0, 3);
    core_op("lbu_9", 1'b0, F3_BU, 32'h9, 32'h0, 32'h0000_00AA, 1'b0, 3);
    core_op("sh_a", 1'b1, F3_H, 32'hA, 32'h1234_BEEF, 32'h0, 1'b0, 4);
    drain();
    chk("sh_a_word", mem[2], 32'hBEEF_AA44);
    core_op("lh_a", 1'b0, F3_H, 32'hA, 32'h0, 32'hFFFF_BEEF, 1'b0, 3);
    core_op("lhu_a", 1'b0, F3_HU, 32'hA, 32'h0, 32'h0000_BEEF, 1'b0, 3);
    drain();

    // Rejected accesses never touch memory.
    cnt0 = mem_en_cnt;
    core_op("lh_3", 1'b0, F3_H, 32'h3, 32'h0, 32'h0, 1'b1, 1);
    core_op("sw_6", 1'b1, F3_W, 32'h6, 32'h1, 32'h0, 1'b1, 1);
    core_op("f3_011", 1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1'b1, 1);
    core_op("sbu", 1'b1, F3_BU, 32'h0, 32'h0, 32'h0, 1'b1, 1);
    drain();
    chk("err_mem_en_cnt", mem_en_cnt - cnt0, 32'h0);

    // Both requesters held high: four core grants, then the loader.
    c_req = 1'b1; c_we = 1'b0; c_funct3 = F3_W; c_addr = 32'h0; c_wdata = 32'h0;
    l_req = 1'b1; l_addr = 32'h40; l_wdata = 32'hA5A5_0F0F;
    grants = 0; seq = '0; n = 0;
    while (grants < 10 && n < 200) begin
      @(negedge clk);
      n++;
      if (c_ready) begin
        e.name = "starve_lw"; e.rdata = 32'h0; e.err = 1'b0; e.lat = 3; e.acc = cyc;
        exp_q.push_back(e);
        grants++;
      end else if (l_ready) begin
        seq[grants] = 1'b1;
        grants++;
      end
    end
    @(posedge clk); #1;
    c_req = 1'b0; l_req = 1'b0;
    chk("starve_grants", 32'(grants), 32'd10);
    chk("starve_pattern", 32'(seq), 32'h210);
    drain();
    chk("starve_l_word", mem[16], 32'hA5A5_0F0F);

    // Loader writes and address aliasing.
    l_op("l_7c", 32'h7C, 32'h1234_5678);
    chk_wr("l_7c_mem", 5'd31, 32'h1234_5678);
    core_op("lw_7c", 1'b0, F3_W, 32'h7C, 32'h0, 32'h1234_5678, 1'b0, 3);
    core_op("lw_87c", 1'b0, F3_W, 32'h87C, 32'h0, 32'h1234_5678, 1'b0, 3);
    drain();
    l_op("l_87e", 32'h87E, 32'hCAFE_F00D);
    chk_wr("l_87e_mem", 5'd31, 32'hCAFE_F00D);
    core_op("lw_7c_b", 1'b0, F3_W, 32'h7C, 32'h0, 32'hCAFE_F00D, 1'b0, 3);
    drain();

    // Reset during the merge write of a byte store drops the operation.
    core_op("sb_8_rst", 1'b1, F3_B, 32'h8, 32'h55, 32'h0, 1'b0, 4);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mrg_reached_we", 32'(mem_we), 32'h1);
    n_rst = 1'b0;
    #1;
    exp_q.delete();
    chk_idle_outputs("mid_rst");
    @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (4) @(negedge clk);
    chk_idle_outputs("post_rst");
    chk("post_rst_word", mem[2], 32'hBEEF_AA44);
    @(posedge clk); #1;
    core_op("lw_8_post", 1'b0, F3_W, 32'h8, 32'h0, 32'hBEEF_AA44, 1'b0, 3);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
